// File: rtl/s2p_collector.sv
// rtl/s2p_collector.sv - LSB-first serial-to-parallel word collector with single-entry output slot
//
// Gathers a framed, bit-serial stream into WIDTH-bit words and presents each
// completed word on a holding register with a valid/ready handshake. Words that
// complete while the slot is still occupied are dropped and recorded in a
// sticky overflow flag.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   bit_in       serial data bit, LSB first
//   bit_valid    bit_in is sampled on this edge only when high
//   frame_start  with bit_valid, marks bit_in as bit 0 of a new word
//   word_ready   consumer accepts word_out on this edge when word_valid is high
//   clr_ovf      synchronous clear of overflow (a same-edge drop wins)
//   word_out     assembled word, stable while word_valid is high
//   word_valid   word_out holds an unconsumed word
//   busy         high while collecting a frame
//   overflow     sticky, a completed word was dropped

module s2p_collector #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    input  logic             word_ready,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             busy,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-2:0]   sr_q;
    logic [WIDTH-1:0]   word_out_q;
    logic               word_valid_q;
    logic               overflow_q;

    logic               complete_d;
    logic               slot_free_d;
    logic               load_d;
    logic               drop_d;

    // A word completes on the last data bit of a frame; a frame_start on that
    // same edge takes priority and restarts the frame instead.
    always_comb begin
        complete_d  = 1'b0;
        if (state_q == COLLECT && bit_valid && !frame_start && cnt_q == LAST_IDX) begin
            complete_d = 1'b1;
        end
        // The slot counts as free when the consumer empties it on this same edge.
        slot_free_d = !word_valid_q || word_ready;
        load_d      = complete_d && slot_free_d;
        drop_d      = complete_d && !slot_free_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            // Output slot: a load overrides a simultaneous consume.
            if (load_d) begin
                word_out_q   <= {bit_in, sr_q};
                word_valid_q <= 1'b1;
            end else if (word_valid_q && word_ready) begin
                word_valid_q <= 1'b0;
            end

            if (drop_d) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (bit_valid && frame_start) begin
                        sr_q[0] <= bit_in;
                        cnt_q   <= CW'(1);
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (bit_valid) begin
                        if (frame_start) begin
                            sr_q[0] <= bit_in;
                            cnt_q   <= CW'(1);
                        end else if (cnt_q == LAST_IDX) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            sr_q[cnt_q] <= bit_in;
                            cnt_q       <= cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q == COLLECT);

endmodule

// File: tb/tb_s2p_collector.sv
// tb/tb_s2p_collector.sv - directed self-checking bench for s2p_collector

module tb_s2p_collector;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bit_in_r = 1'b0;
    logic       bit_valid_r = 1'b0;
    logic       frame_start_r = 1'b0;
    logic       word_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] word_out;
    logic       word_valid;
    logic       busy;
    logic       overflow;

    int vectors = 0;
    int miscompares = 0;

    // Upstream serial 2's-complement stage: passes bits up to and including the
    // first 1, inverts the rest; outputs registered, so valid lags by one cycle.
    logic use_up = 1'b0;
    logic u_bit = 1'b0;
    logic u_valid = 1'b0;
    logic u_start = 1'b0;
    logic up_seen = 1'b0;
    logic up_bit_q = 1'b0;
    logic up_valid_q = 1'b0;
    logic up_start_q = 1'b0;

    always @(posedge clk) begin
        up_valid_q <= u_valid;
        up_start_q <= u_start;
        if (u_valid) begin
            if (u_start) begin
                up_bit_q <= u_bit;
                up_seen  <= u_bit;
            end else begin
                up_bit_q <= up_seen ? ~u_bit : u_bit;
                up_seen  <= up_seen | u_bit;
            end
        end
    end

    logic dut_bit;
    logic dut_valid;
    logic dut_start;
    assign dut_bit   = use_up ? up_bit_q   : bit_in_r;
    assign dut_valid = use_up ? up_valid_q : bit_valid_r;
    assign dut_start = use_up ? up_start_q : frame_start_r;

    s2p_collector #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_in      (dut_bit),
        .bit_valid   (dut_valid),
        .frame_start (dut_start),
        .word_ready  (word_ready),
        .clr_ovf     (clr_ovf),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic drive_bit(input logic b, input logic v, input logic fs, input logic rdy);
        @(negedge clk);
        bit_in_r      = b;
        bit_valid_r   = v;
        frame_start_r = fs;
        word_ready    = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input logic rdy);
        drive_bit(1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic send_word(input logic [7:0] d, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i], 1'b1, (i == 0), (i == 7) ? rdy_last : 1'b0);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (word_out !== 8'h00 || word_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: out=%h v=%b busy=%b ovf=%b, required 00 0 0 0",
                     word_out, word_valid, busy, overflow);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        logic [7:0] d = 8'hB4;
        int busy_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i], 1'b1, (i == 0), 1'b0);
            if (busy === 1'b1) busy_cycles++;
        end
        idle_cycle(1'b0);
        if (busy === 1'b1) busy_cycles++;
        vectors++;
        if (word_out !== 8'hB4 || word_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_word: out=%h v=%b, required b4 1", word_out, word_valid);
        end
        vectors++;
        if (busy_cycles != 7) begin
            miscompares++;
            $display("FAIL basic_busy_cycles: got %0d, required 7", busy_cycles);
        end
        vectors++;
        if (overflow !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_flags: ovf=%b busy=%b, required 0 0", overflow, busy);
        end
        idle_cycle(1'b1);
        vectors++;
        if (word_valid !== 1'b0 || word_out !== 8'hB4) begin
            miscompares++;
            $display("FAIL basic_consume: v=%b out=%h, required 0 b4", word_valid, word_out);
        end
        idle_cycle(1'b0);
    endtask

    task automatic test_gapped_chain;
        logic [7:0] d = 8'h05;
        use_up = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            u_bit = d[i]; u_valid = 1'b1; u_start = (i == 0);
            @(posedge clk);
            #1;
            @(negedge clk);
            u_valid = 1'b0; u_start = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        @(negedge clk);
        u_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (word_out !== 8'hFB || word_valid !== 1'b1 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL gapped_chain: out=%h v=%b ovf=%b, required fb 1 0",
                     word_out, word_valid, overflow);
        end
        @(negedge clk);
        use_up = 1'b0;
        idle_cycle(1'b1);
        idle_cycle(1'b0);
    endtask

    task automatic test_restart;
        drive_bit(1'b1, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
        send_word(8'h3C, 1'b0);
        idle_cycle(1'b0);
        vectors++;
        if (word_out !== 8'h3C || word_valid !== 1'b1 || overflow !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL restart: out=%h v=%b ovf=%b busy=%b, required 3c 1 0 0",
                     word_out, word_valid, overflow, busy);
        end
        idle_cycle(1'b1);
        vectors++;
        if (word_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_single_word: v=%b, required 0", word_valid);
        end
    endtask

    task automatic test_overflow;
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        vectors++;
        if (word_out !== 8'h11 || word_valid !== 1'b1 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_drop: out=%h v=%b ovf=%b, required 11 1 1",
                     word_out, word_valid, overflow);
        end
        idle_cycle(1'b1);
        vectors++;
        if (word_valid !== 1'b0 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_sticky: v=%b ovf=%b, required 0 1", word_valid, overflow);
        end
        @(negedge clk);
        word_ready = 1'b0;
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clear: ovf=%b, required 0", overflow);
        end
        @(negedge clk);
        clr_ovf = 1'b0;
    endtask

    task automatic test_simultaneous;
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b1);
        vectors++;
        if (word_out !== 8'h22 || word_valid !== 1'b1 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_consume_load: out=%h v=%b ovf=%b, required 22 1 0",
                     word_out, word_valid, overflow);
        end
        idle_cycle(1'b1);
        idle_cycle(1'b0);
    endtask

    task automatic test_back_to_back;
        logic [7:0] w [3] = '{8'h5A, 8'hFF, 8'h80};
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                drive_bit(w[k][i], 1'b1, (i == 0), 1'b1);
            end
            vectors++;
            if (word_out !== w[k] || word_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL back_to_back_%0d: out=%h v=%b, required %h 1",
                         k, word_out, word_valid, w[k]);
            end
        end
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_back_ovf: ovf=%b, required 0", overflow);
        end
        idle_cycle(1'b1);
        idle_cycle(1'b0);
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] junk = 8'h6B;
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_bit(junk[i], 1'b1, (i == 0), 1'b0);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (word_out !== 8'h00 || word_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: out=%h v=%b busy=%b ovf=%b, required 00 0 0 0",
                     word_out, word_valid, busy, overflow);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_bit(junk[i], 1'b1, 1'b0, 1'b0);
        end
        vectors++;
        if (busy !== 1'b0 || word_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_unframed_ignored: busy=%b v=%b, required 0 0", busy, word_valid);
        end
        send_word(8'hA5, 1'b0);
        vectors++;
        if (word_out !== 8'hA5 || word_valid !== 1'b1 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_next_word: out=%h v=%b ovf=%b, required a5 1 0",
                     word_out, word_valid, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped_chain();
        test_restart();
        test_overflow();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/s2p_collector.md
# s2p_collector

Serial-to-parallel collector that sits directly downstream of the bit-serial 2's-complement FSM. It gathers an LSB-first serial bit stream into WIDTH-bit words, framed by a start strobe. Each completed word is presented on a single-entry output register with a valid/ready handshake. Words that complete while the output register is still occupied are dropped and flagged with a sticky overflow flag.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- bit_in  input  1  serial data bit, LSB of the word first.
- bit_valid  input  1  bit_in is sampled on this edge only when high.
- frame_start  input  1  qualified by bit_valid; marks bit_in as bit 0 of a new word.
- word_ready  input  1  consumer accepts word_out this edge when word_valid is high.
- clr_ovf  input  1  synchronous clear of overflow.
- word_out  output  WIDTH  assembled word; stable while word_valid is high.
- word_valid  output  1  word_out holds an unconsumed word.
- busy  output  1  high while state is COLLECT.
- overflow  output  1  sticky; a completed word was dropped.

## Operation
- The block has two states, IDLE and COLLECT. It also has:
  - a bit counter cnt, range 0..WIDTH-1;
  - a shift register sr of WIDTH-1 bits;
  - an output holding register word_out, with its valid flag word_valid.
- Reset (asynchronous) forces state=IDLE, cnt=0, sr=0, word_out=0, word_valid=0, overflow=0 and busy=0. Reset asserted mid-word discards the partial word.
- **IDLE:**
  - bit_valid=1 with frame_start=1: sr[0]<=bit_in, cnt<=1, go to COLLECT.
  - bit_valid=1 with frame_start=0: the bit is ignored.
  - bit_valid=0: hold.
- **COLLECT, bit_valid=0:** hold all state; gaps of any length are allowed.
- **COLLECT, bit_valid=1, frame_start=1:** the partial word is discarded and the bit restarts the frame: sr[0]<=bit_in, cnt<=1. No flag is raised.
- **COLLECT, bit_valid=1, frame_start=0, cnt<WIDTH-1:** sr[cnt]<=bit_in, cnt<=cnt+1.
- **COLLECT, bit_valid=1, frame_start=0, cnt==WIDTH-1 (word complete):**
  - The completed word is {bit_in, sr[WIDTH-2:0]}.
  - The slot is free if word_valid=0, or if word_valid=1 and word_ready=1 on this same edge.
  - If the slot is free: word_out<=completed word and word_valid<=1.
  - Otherwise: the completed word is dropped, overflow<=1, and word_out/word_valid are unchanged.
  - In both cases: cnt<=0, state<=IDLE.
- **Handshake:**
  - word_valid=1 and word_ready=1 with no load on the same edge: word_valid<=0, and word_out keeps its last value.
  - word_ready while word_valid=0 has no effect.
- **overflow:**
  - Set only by a dropped word.
  - Cleared by clr_ovf=1, unless a drop occurs on the same edge, in which case set wins.
- busy = (state==COLLECT), decoded from the registered state.

## Timing
- The last bit is sampled at rising edge k. word_valid is high and word_out is valid from edge k onward, i.e. usable in cycle k+1.
- Minimum frame: WIDTH consecutive edges with bit_valid=1, giving one word per WIDTH cycles at full rate.
- Back-to-back frames are legal: frame_start may arrive on the edge immediately after a completion, because state is IDLE then.
- A consumer holding word_ready=1 permanently sustains full rate with no overflow.
- With word_ready=0, the first word is held. The second completed word sets overflow at its completion edge k2, visible from k2.
- Inputs are sampled only on the rising edge. There are no combinational paths from inputs to outputs.

## Test plan
- **Basic word, WIDTH=8, word_ready=1 after valid:** send 0xB4 LSB-first (0,0,1,0,1,1,0,1) with frame_start on the first bit. Required: word_out=0xB4 and word_valid=1 right after the 8th edge; busy high for exactly 7 cycles; overflow=0.
- **Gapped bits and upstream chaining:** feed 0x05 through the serial 2's-complement FSM, with bit_valid delayed one cycle to match its registered output, and insert random bit_valid=0 gaps. Required: word_out=0xFB.
- **Restart mid-word:** send 3 bits, then frame_start with a full 0x3C. Required: a single word 0x3C; no overflow.
- **Overflow:** with word_ready=0, send 0x11 then 0x22. Required: word_out stays 0x11, word_valid=1, overflow=1. Then pulse word_ready: word_valid drops and overflow stays 1. Then clr_ovf=1: overflow=0.
- **Simultaneous consume and completion:** with 0x11 held, assert word_ready=1 on the edge where 0x22 completes. Required: word_out=0x22, word_valid stays 1, overflow=0.
- **Reset mid-frame:** assert reset asynchronously after 5 bits. Required: all outputs immediately 0 and busy=0. Bits sent without frame_start afterwards are ignored; the next framed word 0xA5 is received correctly.
